// File: rtl/hazard_pkg.sv
// Shared constants for the hazard unit: bypass selects and performance counter width.
package hazard_pkg;

  localparam logic [1:0] FWD_REG     = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALUOUTM = 2'b10;

  localparam int PERF_CNT_W = 32;

  // M-stage result is newer than W-stage, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    if (hit_m)      return FWD_ALUOUTM;
    else if (hit_w) return FWD_RESULTW;
    else            return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter used for the hazard performance counters.
module sat_counter #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall, PC-write stall/flush tracking.
// Optional stall/flush performance counters are built when HAZARD_PERF_EN is defined.
module hazard_unit
  import hazard_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Match_1E_M,
  input  logic                  Match_1E_W,
  input  logic                  Match_2E_M,
  input  logic                  Match_2E_W,
  input  logic                  Match_12D_E,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  BranchTakenE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic [PERF_CNT_W-1:0] StallCount,
  output logic [PERF_CNT_W-1:0] FlushCount
);

  logic ldr_stall;
  logic pc_wr_pending_f;
  logic pend_e, pend_m, pend_w;

  always_comb begin
    ForwardAE = fwd_sel(Match_1E_M & RegWriteM, Match_1E_W & RegWriteW);
    ForwardBE = fwd_sel(Match_2E_M & RegWriteM, Match_2E_W & RegWriteW);
  end

  // A taken branch squashes the load in E, so the load-use stall is moot.
  assign ldr_stall       = Match_12D_E & MemtoRegE & ~BranchTakenE;
  assign pc_wr_pending_f = PCSrcD | pend_e | pend_m;

  assign StallF = ldr_stall | pc_wr_pending_f;
  assign StallD = ldr_stall;
  assign FlushD = pc_wr_pending_f | pend_w | BranchTakenE;
  assign FlushE = ldr_stall | BranchTakenE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_e <= 1'b0;
      pend_m <= 1'b0;
      pend_w <= 1'b0;
    end else begin
      pend_e <= PCSrcD & ~FlushE;
      pend_m <= PCSrcE;
      pend_w <= pend_m;
    end
  end

`ifdef HAZARD_PERF_EN
  sat_counter #(.width(PERF_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallD | StallF),
    .count (StallCount)
  );

  sat_counter #(.width(PERF_CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushD | FlushE),
    .count (FlushCount)
  );
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: spec-level model checked every cycle plus directed literals.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, BranchTakenE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallF, StallD, FlushD, FlushE;
  logic [31:0] StallCount, FlushCount;

  int tests = 0;
  int fails = 0;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
    .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W),
    .Match_12D_E(Match_12D_E),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .BranchTakenE(BranchTakenE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Age of each in-flight PC write, in cycles: a decoded PC write that was
  // not flushed becomes "in E" next cycle; a resolved PCSrcE is "in M" next
  // cycle and "in W" the one after.
  bit in_e, in_m, in_w;
  longint m_stall_cnt, m_flush_cnt;
  bit model_en = 1'b1;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe;
  } exp_t;

  function automatic logic [1:0] fwd(input logic mm, input logic ww);
    return mm ? 2'd2 : (ww ? 2'd1 : 2'd0);
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    logic lu, pcw;
    lu   = Match_12D_E && MemtoRegE && !BranchTakenE;
    pcw  = PCSrcD || in_e || in_m;
    e.fa = fwd(Match_1E_M && RegWriteM, Match_1E_W && RegWriteW);
    e.fb = fwd(Match_2E_M && RegWriteM, Match_2E_W && RegWriteW);
    e.sd = lu;
    e.sf = lu || pcw;
    e.fd = pcw || in_w || BranchTakenE;
    e.fe = lu || BranchTakenE;
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    exp_t e;
    if (reset) begin
      in_e = 0; in_m = 0; in_w = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      e = expect_now();
`ifdef HAZARD_PERF_EN
      if ((e.sf || e.sd) && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
      if ((e.fd || e.fe) && m_flush_cnt < 64'hFFFF_FFFF) m_flush_cnt++;
`endif
      in_w = in_m;
      in_m = PCSrcE;
      in_e = PCSrcD && !e.fe;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (model_en) begin
      e = expect_now();
      chk("m_ForwardAE", {30'd0, ForwardAE}, {30'd0, e.fa});
      chk("m_ForwardBE", {30'd0, ForwardBE}, {30'd0, e.fb});
      chk("m_StallF", {31'd0, StallF}, {31'd0, e.sf});
      chk("m_StallD", {31'd0, StallD}, {31'd0, e.sd});
      chk("m_FlushD", {31'd0, FlushD}, {31'd0, e.fd});
      chk("m_FlushE", {31'd0, FlushE}, {31'd0, e.fe});
      chk("m_StallCount", StallCount, m_stall_cnt[31:0]);
      chk("m_FlushCount", FlushCount, m_flush_cnt[31:0]);
    end
  end

  // ---------------- stimulus ----------------
  // {m1m,m1w,m2m,m2w,m12,rwm,rww,mre,pcd,pce,bt}
  task automatic drive(input logic [10:0] v);
    {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E,
     RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, BranchTakenE} = v;
  endtask

  // Start a new cycle: inputs change just after the rising edge.
  task automatic cyc(input logic [10:0] v);
    @(posedge clk); #1;
    drive(v);
  endtask

  // Look at outputs mid-cycle, after the model's own check.
  task automatic mid();
    @(negedge clk); #1;
  endtask

  localparam logic [10:0] IDLE = 11'b0;
  localparam logic [10:0] LOADUSE = 11'b00001_001_000;

  logic [10:0] table_v [10] = '{
    11'b10100_110_000, 11'b01010_011_000, 11'b11110_100_000, 11'b11110_010_000,
    11'b00001_001_001, 11'b00000_000_100, 11'b00000_000_010, 11'b00001_001_100,
    11'b10001_111_011, 11'b00000_000_000
  };

  initial begin
    drive(IDLE);
    reset = 1'b1;
    #2;
    chk("rst_StallF", {31'd0, StallF}, 32'd0);
    chk("rst_FlushD", {31'd0, FlushD}, 32'd0);
    chk("rst_FwdA", {30'd0, ForwardAE}, 32'd0);
    chk("rst_StallCount", StallCount, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Forwarding priority
    cyc(11'b11000_110_000); mid();
    chk("fwdA_M", {30'd0, ForwardAE}, 32'd2);
    cyc(11'b11000_010_000); mid();
    chk("fwdA_W", {30'd0, ForwardAE}, 32'd1);
    cyc(11'b11000_000_000); mid();
    chk("fwdA_reg", {30'd0, ForwardAE}, 32'd0);
    cyc(11'b00110_110_000); mid();
    chk("fwdB_M", {30'd0, ForwardBE}, 32'd2);

    // Load-use: one cycle only
    cyc(LOADUSE); mid();
    chk("lu_StallF", {31'd0, StallF}, 32'd1);
    chk("lu_StallD", {31'd0, StallD}, 32'd1);
    chk("lu_FlushE", {31'd0, FlushE}, 32'd1);
    chk("lu_FlushD", {31'd0, FlushD}, 32'd0);
    cyc(IDLE); mid();
    chk("lu_after_StallF", {31'd0, StallF}, 32'd0);

    // PC-write sequence: StallF cycles 0-2, FlushD cycles 0-3
    cyc(11'b00000_000_100); mid();
    chk("pc0_StallF", {31'd0, StallF}, 32'd1);
    chk("pc0_FlushD", {31'd0, FlushD}, 32'd1);
    cyc(11'b00000_000_010); mid();
    chk("pc1_StallF", {31'd0, StallF}, 32'd1);
    cyc(IDLE); mid();
    chk("pc2_StallF", {31'd0, StallF}, 32'd1);
    chk("pc2_FlushD", {31'd0, FlushD}, 32'd1);
    cyc(IDLE); mid();
    chk("pc3_StallF", {31'd0, StallF}, 32'd0);
    chk("pc3_FlushD", {31'd0, FlushD}, 32'd1);
    cyc(IDLE); mid();
    chk("pc4_FlushD", {31'd0, FlushD}, 32'd0);
    chk("pc4_StallF", {31'd0, StallF}, 32'd0);

    // Condition failed: stall ends after the pend_e cycle
    cyc(11'b00000_000_100);
    cyc(IDLE); mid();
    chk("nc1_StallF", {31'd0, StallF}, 32'd1);
    cyc(IDLE); mid();
    chk("nc2_StallF", {31'd0, StallF}, 32'd0);
    chk("nc2_FlushD", {31'd0, FlushD}, 32'd0);

    // Branch wins over load-use
    cyc(11'b00001_001_001); mid();
    chk("br_StallD", {31'd0, StallD}, 32'd0);
    chk("br_StallF", {31'd0, StallF}, 32'd0);
    chk("br_FlushD", {31'd0, FlushD}, 32'd1);
    chk("br_FlushE", {31'd0, FlushE}, 32'd1);

    // Reset mid PC-write sequence
    cyc(11'b00000_000_100);
    @(posedge clk); #1;
    drive(IDLE);
    reset = 1'b1;
    #1;
    chk("rmid_StallF", {31'd0, StallF}, 32'd0);
    chk("rmid_FlushD", {31'd0, FlushD}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mid();
    chk("rrel_StallF", {31'd0, StallF}, 32'd0);
    chk("rrel_FlushD", {31'd0, FlushD}, 32'd0);

    for (int i = 0; i < 10; i++) cyc(table_v[i]);
    cyc(IDLE);

`ifdef HAZARD_PERF_EN
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cyc(LOADUSE);
    cyc(IDLE); mid();
    chk("perf_StallCount5", StallCount, 32'd5);
    chk("perf_FlushCount5", FlushCount, 32'd5);
    model_en = 1'b0;
    force dut.u_stall_cnt.count = 32'hFFFF_FFFD;
    #1;
    release dut.u_stall_cnt.count;
    m_stall_cnt = 64'hFFFF_FFFD;
    model_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc(LOADUSE);
    cyc(IDLE); mid();
    chk("perf_StallSat", StallCount, 32'hFFFF_FFFF);
`else
    mid();
    chk("noperf_StallCount", StallCount, 32'd0);
    chk("noperf_FlushCount", FlushCount, 32'd0);
`endif

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
